// File: rtl/wallace_pkg.sv
// Shared types and sizing constants for the nibble-serial Wallace MAC.
package wallace_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    localparam int NIB_W   = 4;
    localparam int OP_W    = 8;
    localparam int N_STEPS = 4;

endpackage

// File: rtl/wallace_seq_mac8_if.sv
// Operand/result valid-ready bundle between the MAC, its source and its consumer.
interface wallace_seq_mac8_if
    import wallace_pkg::*;
#(
    parameter int ACC_W = 20
);
    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  in_a;
    logic [OP_W-1:0]  in_b;
    logic             in_acc;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;

    modport master (
        output in_valid, in_a, in_b, in_acc, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_a, in_b, in_acc, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/full_adder.sv
// One-bit full adder; carry is the majority of the three inputs.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/wallace4.sv
// Combinational 4x4 unsigned Wallace multiplier: one carry-save reduction layer,
// then a single carry-propagate add of the three remaining rows.
module wallace4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [3:0] pp [4];
    logic       h1s, h1c, h5s, h5c;
    logic       f2s, f2c, f3s, f3c, f4s, f4c;
    logic [6:0] row0, row1;
    logic [7:0] row2;

    // pp[i][j] carries weight 2^(i+j)
    for (genvar i = 0; i < 4; i++) begin : g_pp
        assign pp[i] = a & {4{b[i]}};
    end

    assign h1s = pp[0][1] ^ pp[1][0];
    assign h1c = pp[0][1] & pp[1][0];
    assign h5s = pp[2][3] ^ pp[3][2];
    assign h5c = pp[2][3] & pp[3][2];

    full_adder u_fa2 (.a(pp[0][2]), .b(pp[1][1]), .cin(pp[2][0]), .sum(f2s), .cout(f2c));
    full_adder u_fa3 (.a(pp[0][3]), .b(pp[1][2]), .cin(pp[2][1]), .sum(f3s), .cout(f3c));
    full_adder u_fa4 (.a(pp[1][3]), .b(pp[2][2]), .cin(pp[3][1]), .sum(f4s), .cout(f4c));

    assign row0 = {pp[3][3], h5s, f4s, f3s, f2s, h1s, pp[0][0]};
    assign row1 = {h5c, f4c, f3c, f2c, h1c, 2'b00};
    assign row2 = {4'b0000, pp[3][0], 3'b000};

    assign p = {1'b0, row0} + {1'b0, row1} + row2;
endmodule

// File: rtl/wallace_seq_mac8.sv
// Sequential 8x8 multiply-accumulate: one nibble-pair product per MUL cycle,
// shifted into place and summed into a wrapping accumulator.
module wallace_seq_mac8
    import wallace_pkg::*;
#(
    parameter int ACC_W = 20
) (
    input logic               clk,
    input logic               rst,
    wallace_seq_mac8_if.slave bus
);
    localparam int STEP_W = $clog2(N_STEPS);

    state_t              state;
    state_t              state_next;
    logic [STEP_W-1:0]   step;
    logic [OP_W-1:0]     a_reg;
    logic [OP_W-1:0]     b_reg;
    logic [ACC_W-1:0]    acc;
    logic [NIB_W-1:0]    a_nib;
    logic [NIB_W-1:0]    b_nib;
    logic [2*NIB_W-1:0]  p4;
    logic [1:0]          nib_pos;
    logic [ACC_W-1:0]    p_shifted;
    logic                accept;
    logic                last_step;

    assign accept    = (state == IDLE) && bus.in_valid;
    assign last_step = (step == STEP_W'(N_STEPS - 1));

    // step[0] walks the a nibbles, step[1] the b nibbles
    assign a_nib   = step[0] ? a_reg[OP_W-1:NIB_W] : a_reg[NIB_W-1:0];
    assign b_nib   = step[1] ? b_reg[OP_W-1:NIB_W] : b_reg[NIB_W-1:0];
    assign nib_pos = {1'b0, step[0]} + {1'b0, step[1]};

    wallace4 u_mul (
        .a (a_nib),
        .b (b_nib),
        .p (p4)
    );

    assign p_shifted = ACC_W'(p4) << {nib_pos, 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept)        state_next = MUL;
            MUL:  if (last_step)     state_next = DONE;
            DONE: if (bus.out_ready) state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.out_data  = acc;
    end

    // acc survives DONE->IDLE so an in_acc=1 follow-on can build on it
    always_ff @(posedge clk) begin
        if (rst) begin
            step  <= '0;
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg <= bus.in_a;
                        b_reg <= bus.in_b;
                        step  <= '0;
                        if (!bus.in_acc) acc <= '0;
                    end
                end
                MUL: begin
                    acc  <= acc + p_shifted;
                    step <= step + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_wallace_seq_mac8.sv
// Directed and random checks of the nibble-serial MAC: table vectors, wrap,
// backpressure, mid-operation reset and a random operand sweep.
module tb_wallace_seq_mac8;
    localparam int ACC_W = 20;

    typedef struct {
        logic [7:0]       a;
        logic [7:0]       b;
        logic             acc;
        logic [ACC_W-1:0] expected;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    wallace_seq_mac8_if #(.ACC_W(ACC_W)) bus ();

    wallace_seq_mac8 #(.ACC_W(ACC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Runs one full transaction from IDLE; called just after a rising edge.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic acc_mode,
                                 output logic [ACC_W-1:0] result, output int latency);
        checkOutput("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_acc   = acc_mode;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_a     = 8'($urandom);
        bus.in_b     = 8'($urandom);
        bus.in_acc   = 1'($urandom);
        latency = 0;
        while (!bus.out_valid && latency < 20) begin
            checkOutput("in_ready_busy", 32'(bus.in_ready), 32'd0);
            @(posedge clk); #1;
            latency++;
        end
        result = '0;
        if (!bus.out_valid) begin
            checkOutput("out_valid_timeout", 32'd0, 32'd1);
            return;
        end
        checkOutput("in_ready_done", 32'(bus.in_ready), 32'd0);
        result = bus.out_data;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checkOutput("out_valid_clear", 32'(bus.out_valid), 32'd0);
    endtask

    vec_t vecs [10];

    initial begin
        logic [ACC_W-1:0] res;
        int               lat;
        int               wait_cnt;
        logic [7:0]       ra;
        logic [7:0]       rb;

        vecs[0] = '{8'h12, 8'h34, 1'b0, 20'h003A8};
        vecs[1] = '{8'hFF, 8'hFF, 1'b0, 20'h0FE01};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 20'h1FC02};
        vecs[3] = '{8'hFF, 8'hFF, 1'b1, 20'h2FA03};
        vecs[4] = '{8'h05, 8'h07, 1'b0, 20'h00023};
        vecs[5] = '{8'h80, 8'h02, 1'b0, 20'h00100};
        vecs[6] = '{8'h00, 8'hAB, 1'b0, 20'h00000};
        vecs[7] = '{8'h0F, 8'hF0, 1'b1, 20'h00E10};
        vecs[8] = '{8'hA5, 8'h5A, 1'b0, 20'h03A02};
        vecs[9] = '{8'h01, 8'h01, 1'b1, 20'h03A03};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_acc    = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("reset_out_data", 32'(bus.out_data), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].acc, res, lat);
            checkOutput($sformatf("vec%0d_data", i), 32'(res), 32'(vecs[i].expected));
            checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
        end

        // 17 accumulated 0xFF*0xFF wrap past 2^20
        for (int i = 0; i < 17; i++) begin
            applyStimulus(8'hFF, 8'hFF, (i != 0), res, lat);
        end
        checkOutput("wrap_data", 32'(res), 32'h0DE11);

        // Backpressure in DONE with a busy upstream
        bus.in_valid = 1'b1;
        bus.in_a     = 8'h12;
        bus.in_b     = 8'h34;
        bus.in_acc   = 1'b0;
        @(posedge clk); #1;
        wait_cnt = 0;
        while (!bus.out_valid && wait_cnt < 20) begin
            bus.in_a = 8'($urandom);
            bus.in_b = 8'($urandom);
            @(posedge clk); #1;
            wait_cnt++;
        end
        checkOutput("bp_reach_done", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            bus.in_a   = 8'($urandom);
            bus.in_b   = 8'($urandom);
            bus.in_acc = 1'($urandom);
            @(posedge clk); #1;
            checkOutput("bp_out_data", 32'(bus.out_data), 32'h003A8);
            checkOutput("bp_in_ready", 32'(bus.in_ready), 32'd0);
            checkOutput("bp_out_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checkOutput("bp_release_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("bp_release_ready", 32'(bus.in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("bp_single_handshake", 32'(bus.out_valid), 32'd0);
        applyStimulus(8'h01, 8'h01, 1'b1, res, lat);
        checkOutput("bp_acc_intact", 32'(res), 32'h003A9);

        // Reset while step==2 is being processed
        bus.in_valid = 1'b1;
        bus.in_a     = 8'hFF;
        bus.in_b     = 8'hFF;
        bus.in_acc   = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("midreset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("midreset_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("midreset_acc", 32'(bus.out_data), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("midreset_idle_hold", 32'(bus.out_valid), 32'd0);
        applyStimulus(8'h05, 8'h07, 1'b1, res, lat);
        checkOutput("midreset_follow", 32'(res), 32'h00023);

        // Random operand sweep against a plain integer product
        for (int i = 0; i < 1500; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            applyStimulus(ra, rb, 1'b0, res, lat);
            checkOutput($sformatf("rand_%02h_x_%02h", ra, rb), 32'(res), 32'(ra) * 32'(rb));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
